// File: rtl/count_event_tracker.sv
// count_event_tracker: classifies up/down counter steps, flags wraps, reversals and illegal steps.
// Optional stall detector is built only when TRACKER_STALL_DET_EN is defined.
module count_event_tracker #(
  parameter int WIDTH     = 4,
  parameter int WRAP_W    = 8,
  parameter int STALL_CYC = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic              mode,
  input  logic [WIDTH-1:0]  count_in,
  output logic              wrap_pulse,
  output logic              wrap_dir,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              dir_change,
  output logic [1:0]        state,
  output logic              err,
  output logic              stall
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0]  CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]  CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WRAP_W-1:0] WRAP_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

  if ((STALL_CYC < 32'sd1) || (STALL_CYC > 32'sd255)) begin : g_stall_cyc_range
    $error("STALL_CYC must be within 1..255");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  prev_count_q, prev_count_d;
  logic              prev_valid_q, prev_valid_d;
  logic              last_dir_q, last_dir_d;
  logic              dir_vld_q, dir_vld_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic              wrap_dir_q, wrap_dir_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              dir_change_q, dir_change_d;
  logic              err_q, err_d;
  logic              hold_s, up_s, down_s;

  assign hold_s = (count_in == prev_count_q);
  assign up_s   = (count_in == (prev_count_q + CNT_ONE));
  assign down_s = (count_in == (prev_count_q - CNT_ONE));

  // Step classification, wrap accounting and direction FSM next-state.
  always_comb begin
    state_d      = state_q;
    prev_count_d = prev_count_q;
    prev_valid_d = prev_valid_q;
    last_dir_d   = last_dir_q;
    dir_vld_d    = dir_vld_q;
    wrap_dir_d   = wrap_dir_q;
    wrap_pulse_d = 1'b0;
    dir_change_d = 1'b0;
    err_d        = 1'b0;
    if (en) begin
      prev_count_d = count_in;
      prev_valid_d = 1'b1;
      if (prev_valid_q) begin
        if (hold_s) begin
          state_d = ST_HOLD;
        end else if (up_s) begin
          state_d      = ST_UP;
          last_dir_d   = 1'b0;
          dir_vld_d    = 1'b1;
          dir_change_d = dir_vld_q && last_dir_q;
          err_d        = mode;
          if (prev_count_q == CNT_MAX) begin
            wrap_pulse_d = 1'b1;
            wrap_dir_d   = 1'b0;
          end else begin
            wrap_pulse_d = 1'b0;
          end
        end else if (down_s) begin
          state_d      = ST_DOWN;
          last_dir_d   = 1'b1;
          dir_vld_d    = 1'b1;
          dir_change_d = dir_vld_q && !last_dir_q;
          err_d        = !mode;
          if (prev_count_q == CNT_ZERO) begin
            wrap_pulse_d = 1'b1;
            wrap_dir_d   = 1'b1;
          end else begin
            wrap_pulse_d = 1'b0;
          end
        end else begin
          // Illegal jump: state is deliberately left as it was.
          err_d = 1'b1;
        end
      end else begin
        state_d = state_q;
      end
    end else begin
      prev_count_d = prev_count_q;
    end
    if (wrap_pulse_d && (wrap_cnt_q != WRAP_MAX)) begin
      wrap_cnt_d = wrap_cnt_q + WRAP_ONE;
    end else begin
      wrap_cnt_d = wrap_cnt_q;
    end
  end

  // State and output registers; clr behaves exactly like reset.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state_q      <= ST_INIT;
      prev_count_q <= CNT_ZERO;
      prev_valid_q <= 1'b0;
      last_dir_q   <= 1'b0;
      dir_vld_q    <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_dir_q   <= 1'b0;
      wrap_cnt_q   <= {WRAP_W{1'b0}};
      dir_change_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_count_q <= prev_count_d;
      prev_valid_q <= prev_valid_d;
      last_dir_q   <= last_dir_d;
      dir_vld_q    <= dir_vld_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_dir_q   <= wrap_dir_d;
      wrap_cnt_q   <= wrap_cnt_d;
      dir_change_q <= dir_change_d;
      err_q        <= err_d;
    end
  end

`ifdef TRACKER_STALL_DET_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       stall_q, stall_d;

  // Consecutive HOLD counter; disabled cycles neither count nor clear.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    stall_d    = stall_q;
    if (en && prev_valid_q) begin
      if (hold_s) begin
        if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
        stall_d = (hold_cnt_d >= 8'(STALL_CYC));
      end else begin
        hold_cnt_d = 8'd0;
        stall_d    = 1'b0;
      end
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  // Stall detector registers.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      hold_cnt_q <= 8'd0;
      stall_q    <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      stall_q    <= stall_d;
    end
  end

  assign stall = stall_q;
`else
  assign stall = 1'b0;
`endif

  assign wrap_pulse = wrap_pulse_q;
  assign wrap_dir   = wrap_dir_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign dir_change = dir_change_q;
  assign state      = state_q;
  assign err        = err_q;

endmodule

// File: tb/tb_count_event_tracker.sv
// Scoreboard bench for count_event_tracker: a behavioural model pushes the expected
// output vector per sample, each test task pops and compares it after the edge.
module tb_count_event_tracker;
  localparam int W  = 4;
  localparam int WW = 8;
  localparam int SC = 3;
`ifdef TRACKER_STALL_DET_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, en, clr, mode;
  logic [W-1:0]  count_in;
  logic          wrap_pulse, wrap_dir, dir_change, err, stall;
  logic [WW-1:0] wrap_cnt;
  logic [1:0]    state;

  int total = 0;
  int bad   = 0;
  logic [14:0] sb_q[$];

  // model state
  int       m_prev = 0, m_wcnt = 0, m_hold = 0;
  bit       m_pv = 1'b0, m_ld = 1'b0, m_ldv = 1'b0, m_wdir = 1'b0, m_stall = 1'b0;
  logic [1:0] m_state = 2'd0;

  always #5 clk = ~clk;

  count_event_tracker #(.WIDTH(W), .WRAP_W(WW), .STALL_CYC(SC)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode), .count_in(count_in),
    .wrap_pulse(wrap_pulse), .wrap_dir(wrap_dir), .wrap_cnt(wrap_cnt),
    .dir_change(dir_change), .state(state), .err(err), .stall(stall)
  );

  function automatic logic [14:0] obs();
    return {wrap_pulse, wrap_dir, wrap_cnt, dir_change, state, err, stall};
  endfunction

  function automatic logic [14:0] model(input logic r, input logic c, input logic e,
                                        input logic m, input logic [3:0] v);
    bit wp = 1'b0, dc = 1'b0, er = 1'b0, down = 1'b0;
    int d;
    if (r || c) begin
      m_pv = 0; m_ld = 0; m_ldv = 0; m_wdir = 0; m_stall = 0;
      m_wcnt = 0; m_hold = 0; m_state = 2'd0; m_prev = 0;
    end else if (e) begin
      if (!m_pv) begin
        m_pv = 1'b1;
      end else begin
        d = (int'(v) - m_prev + 16) % 16;
        if (d == 0) begin
          m_state = 2'd3;
          m_hold  = (m_hold < 255) ? m_hold + 1 : 255;
          m_stall = STALL_ON && (m_hold >= SC);
        end else begin
          m_hold = 0; m_stall = 1'b0;
          if (d == 1 || d == 15) begin
            down    = (d == 15);
            er      = (m != down);
            dc      = m_ldv && (m_ld != down);
            m_ld    = down; m_ldv = 1'b1;
            m_state = down ? 2'd2 : 2'd1;
            if ((!down && m_prev == 15) || (down && m_prev == 0)) begin
              wp = 1'b1; m_wdir = down;
              if (m_wcnt < 255) m_wcnt++;
            end
          end else begin
            er = 1'b1;
          end
        end
      end
      m_prev = int'(v);
    end
    return {wp, m_wdir, 8'(m_wcnt), dc, m_state, er, m_stall};
  endfunction

  task automatic drive(input logic r, input logic c, input logic e, input logic m, input int v);
    logic [3:0] vv;
    vv = v[3:0];
    reset = r; clr = c; en = e; mode = m; count_in = vv;
    sb_q.push_back(model(r, c, e, m, vv));
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [14:0] exp;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 7);
      exp = sb_q.pop_front(); total++;
      if (obs() !== exp) begin bad++; $display("FAIL reset_sb[%0d] got=%h want=%h", i, obs(), exp); end
    end
    total++;
    if (obs() !== 15'd0) begin bad++; $display("FAIL reset_vals got=%h want=0", obs()); end
  endtask

  task automatic test_up_ramp();
    logic [14:0] exp;
    int wraps = 0, errs = 0;
    for (int i = 0; i < 18; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, i % 16);
      exp = sb_q.pop_front(); total++;
      if (obs() !== exp) begin bad++; $display("FAIL up_sb[%0d] got=%h want=%h", i, obs(), exp); end
      wraps += int'(wrap_pulse); errs += int'(err);
      if (i == 16) begin
        total++;
        if (wrap_pulse !== 1'b1) begin bad++; $display("FAIL up_wrap_at0 got=%b want=1", wrap_pulse); end
      end
    end
    total++; if (wraps != 1) begin bad++; $display("FAIL up_wrap_count got=%0d want=1", wraps); end
    total++; if (errs != 0) begin bad++; $display("FAIL up_err got=%0d want=0", errs); end
    total++; if (wrap_cnt !== 8'd1) begin bad++; $display("FAIL up_wrap_cnt got=%0d want=1", wrap_cnt); end
    total++; if (wrap_dir !== 1'b0) begin bad++; $display("FAIL up_wrap_dir got=%b want=0", wrap_dir); end
    total++; if (state !== 2'd1) begin bad++; $display("FAIL up_state got=%0d want=1", state); end
  endtask

  task automatic test_down_ramp();
    logic [14:0] exp;
    int vals[7] = '{2, 3, 2, 1, 0, 15, 14};
    int dcs = 0, wraps = 0;
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 1'b1, (i >= 2) ? 1'b1 : 1'b0, vals[i]);
      exp = sb_q.pop_front(); total++;
      if (obs() !== exp) begin bad++; $display("FAIL down_sb[%0d] got=%h want=%h", i, obs(), exp); end
      dcs += int'(dir_change); wraps += int'(wrap_pulse);
    end
    total++; if (dcs != 1) begin bad++; $display("FAIL down_dir_change got=%0d want=1", dcs); end
    total++; if (wraps != 1) begin bad++; $display("FAIL down_wraps got=%0d want=1", wraps); end
    total++; if (wrap_dir !== 1'b1) begin bad++; $display("FAIL down_wrap_dir got=%b want=1", wrap_dir); end
    total++; if (wrap_cnt !== 8'd2) begin bad++; $display("FAIL down_wrap_cnt got=%0d want=2", wrap_cnt); end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL down_state got=%0d want=2", state); end
  endtask

  task automatic test_hold_reverse();
    logic [14:0] exp;
    int       vals[5] = '{5, 6, 6, 6, 5};
    logic [1:0] st[5] = '{2'd0, 2'd1, 2'd3, 2'd3, 2'd2};
    logic     dcx[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
    exp = sb_q.pop_front(); total++;
    if (obs() !== exp) begin bad++; $display("FAIL hold_clr got=%h want=%h", obs(), exp); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, (i == 4) ? 1'b1 : 1'b0, vals[i]);
      exp = sb_q.pop_front(); total++;
      if (obs() !== exp) begin bad++; $display("FAIL hold_sb[%0d] got=%h want=%h", i, obs(), exp); end
      total++;
      if ({state, dir_change} !== {st[i], dcx[i]}) begin
        bad++; $display("FAIL hold_state[%0d] got=%0d/%b want=%0d/%b", i, state, dir_change, st[i], dcx[i]);
      end
    end
  endtask

  task automatic test_jump();
    logic [14:0] exp;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4);
    exp = sb_q.pop_front(); total++;
    if (obs() !== exp) begin bad++; $display("FAIL jump_pre got=%h want=%h", obs(), exp); end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 9);
    exp = sb_q.pop_front(); total++;
    if (obs() !== exp) begin bad++; $display("FAIL jump_sb got=%h want=%h", obs(), exp); end
    total++;
    if ({err, state, wrap_pulse} !== {1'b1, 2'd2, 1'b0}) begin
      bad++; $display("FAIL jump_err got=err%b st%0d want=err1 st2", err, state);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 10);
    exp = sb_q.pop_front(); total++;
    if (obs() !== exp) begin bad++; $display("FAIL mismatch_sb got=%h want=%h", obs(), exp); end
    total++;
    if ({err, state, dir_change} !== {1'b1, 2'd1, 1'b1}) begin
      bad++; $display("FAIL mismatch_err got=err%b st%0d dc%b want=err1 st1 dc1", err, state, dir_change);
    end
  endtask

  task automatic test_en_low();
    logic [14:0] exp;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3);
    exp = sb_q.pop_front(); total++;
    if (obs() !== exp) begin bad++; $display("FAIL enlow_sb got=%h want=%h", obs(), exp); end
    total++;
    if ({wrap_pulse, dir_change, err, state} !== {1'b0, 1'b0, 1'b0, 2'd1}) begin
      bad++; $display("FAIL enlow_hold got=%h want=pulses0 st1", obs());
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 11);
    exp = sb_q.pop_front(); total++;
    if (obs() !== exp) begin bad++; $display("FAIL enlow_resume got=%h want=%h", obs(), exp); end
    total++;
    if ({err, state} !== {1'b0, 2'd1}) begin bad++; $display("FAIL enlow_step got=err%b st%0d want=err0 st1", err, state); end
  endtask

  task automatic test_mid_reset();
    logic [14:0] exp;
    int vals[4] = '{12, 12, 9, 10};
    for (int i = 0; i < 4; i++) begin
      drive((i == 1) ? 1'b1 : 1'b0, 1'b0, 1'b1, 1'b0, vals[i]);
      exp = sb_q.pop_front(); total++;
      if (obs() !== exp) begin bad++; $display("FAIL midrst_sb[%0d] got=%h want=%h", i, obs(), exp); end
    end
    total++;
    if ({state, err, dir_change, wrap_cnt} !== {2'd1, 1'b0, 1'b0, 8'd0}) begin
      bad++; $display("FAIL midrst_restart got=%h want=st1 clean", obs());
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] exp;
    int misses = 0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
    void'(sb_q.pop_front());
    drive(1'b0, 1'b0, 1'b1, 1'b0, 15);
    exp = sb_q.pop_front(); total++;
    if (obs() !== exp) begin bad++; $display("FAIL b2b_first got=%h want=%h", obs(), exp); end
    for (int k = 0; k < 260; k++) begin
      drive(1'b0, 1'b0, 1'b1, (k % 2 == 1) ? 1'b1 : 1'b0, (k % 2 == 0) ? 0 : 15);
      exp = sb_q.pop_front(); total++;
      if (obs() !== exp) begin bad++; $display("FAIL b2b_sb[%0d] got=%h want=%h", k, obs(), exp); end
      if (wrap_pulse !== 1'b1) misses++;
    end
    total++; if (misses != 0) begin bad++; $display("FAIL b2b_pulses got=%0d missing want=0", misses); end
    total++; if (wrap_cnt !== 8'd255) begin bad++; $display("FAIL sat_wrap_cnt got=%0d want=255", wrap_cnt); end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 15);
    exp = sb_q.pop_front(); total++;
    if (obs() !== exp) begin bad++; $display("FAIL sat_hold_sb got=%h want=%h", obs(), exp); end
    total++;
    if ({wrap_pulse, wrap_cnt} !== {1'b0, 8'd255}) begin
      bad++; $display("FAIL sat_after got=wp%b cnt%0d want=wp0 cnt255", wrap_pulse, wrap_cnt);
    end
  endtask

  task automatic test_clr();
    logic [14:0] exp;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3);
    exp = sb_q.pop_front(); total++;
    if (obs() !== exp) begin bad++; $display("FAIL clr_sb got=%h want=%h", obs(), exp); end
    total++;
    if ({wrap_cnt, state, wrap_dir} !== {8'd0, 2'd0, 1'b0}) begin
      bad++; $display("FAIL clr_vals got=cnt%0d st%0d want=cnt0 st0", wrap_cnt, state);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 3);
    exp = sb_q.pop_front(); total++;
    if (obs() !== exp) begin bad++; $display("FAIL clr_first_sb got=%h want=%h", obs(), exp); end
    total++; if (obs() !== 15'd0) begin bad++; $display("FAIL clr_first_quiet got=%h want=0", obs()); end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4);
    exp = sb_q.pop_front(); total++;
    if (obs() !== exp) begin bad++; $display("FAIL clr_step_sb got=%h want=%h", obs(), exp); end
    total++;
    if ({state, dir_change, err} !== {2'd1, 1'b0, 1'b0}) begin
      bad++; $display("FAIL clr_step got=st%0d dc%b err%b want=st1 dc0 err0", state, dir_change, err);
    end
  endtask

  task automatic test_stall();
    logic [14:0] exp;
    int  vals[7] = '{6, 7, 7, 7, 7, 7, 8};
    logic want;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
    void'(sb_q.pop_front());
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, vals[i]);
      exp = sb_q.pop_front(); total++;
      if (obs() !== exp) begin bad++; $display("FAIL stall_sb[%0d] got=%h want=%h", i, obs(), exp); end
      want = STALL_ON && (i == 4 || i == 5);
      total++;
      if (stall !== want) begin bad++; $display("FAIL stall_lvl[%0d] got=%b want=%b", i, stall, want); end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0; mode = 1'b0; count_in = 4'd0;
    test_reset();
    test_up_ramp();
    test_down_ramp();
    test_hold_reverse();
    test_jump();
    test_en_low();
    test_mid_reset();
    test_back_to_back();
    test_clr();
    test_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
